multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-high; forces state FETCH immediately.
REQ-003 SHALL have port: op  in  7  opcode of instruction register (Instr[6:0]).
REQ-004 SHALL have port: funct3  in  3  Instr[14:12].
REQ-005 SHALL have port: funct7b5  in  1  Instr[30].
REQ-006 SHALL have port: Zero  in  1  ALU zero flag.
REQ-007 SHALL have port: MemReady  in  1  memory access completes this cycle.
REQ-008 SHALL have ports: PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal, Retire  out  1 each.
REQ-009 SHALL have ports: ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  out  2 each; ALUControl  out  4.

Function
REQ-010 SHALL hold a registered state: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, TRAP.
REQ-011 SHALL transition: FETCH->DECODE only when MemReady=1, else stay in FETCH.
REQ-012 SHALL transition from DECODE by op: 0000011/0100011->MEMADR; 0110011->EXECUTER; 0010011->EXECUTEI; 1100011->BEQ; 1101111->JAL; any other->TRAP.
REQ-013 SHALL transition: MEMADR->MEMREAD if op=0000011, else MEMWRITE; MEMREAD->MEMWB when MemReady=1, else stay; MEMWRITE->FETCH when MemReady=1, else stay.
REQ-014 SHALL transition: EXECUTER/EXECUTEI/JAL->ALUWB; MEMWB, ALUWB, BEQ->FETCH; TRAP->TRAP until reset.
REQ-015 SHALL drive every output 0 unless listed for the current state below.
REQ-016 FETCH SHALL drive: ALUSrcA=00, ALUSrcB=10, ALUop add, ResultSrc=10; IRWrite=1 and PCWrite=1 only in the cycle MemReady=1.
REQ-017 DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target). MEMADR: ALUSrcA=10, ALUSrcB=01, add.
REQ-018 MEMREAD: AdrSrc=1. MEMWRITE: AdrSrc=1, MemWrite=1 held every cycle until MemReady=1. MEMWB: ResultSrc=01, RegWrite=1.
REQ-019 EXECUTER: ALUSrcA=10, ALUSrcB=00, funct decode. EXECUTEI: ALUSrcA=10, ALUSrcB=01, funct decode. ALUWB: RegWrite=1.
REQ-020 BEQ: ALUSrcA=10, ALUSrcB=00, subtract, PCWrite=Zero.
REQ-021 JAL: ALUSrcA=01, ALUSrcB=10, add, PCWrite=1.
REQ-022 ImmSrc SHALL be combinational from op in all states: I-type/load 00, store 01, branch 10, jal 11, other 00.
REQ-023 ALUControl SHALL encode: add 0000, sub 1000, slt 0010, or 0110, and 0111.
REQ-024 Funct decode SHALL select by funct3: 000 -> sub if funct7b5&op[5], else add; 010 slt; 110 or; 111 and; other -> add.
REQ-025 Illegal SHALL be 1 in every cycle in TRAP, 0 otherwise; in TRAP all other outputs 0.
REQ-026 Retire SHALL pulse 1 for one cycle on the last cycle of each instruction: MEMWB, ALUWB, BEQ, or MEMWRITE with MemReady=1.
REQ-027 MemReady SHALL be ignored in states other than FETCH, MEMREAD, MEMWRITE.

Reset
REQ-028 reset=1 SHALL force FETCH asynchronously; while asserted, IRWrite, PCWrite, MemWrite, RegWrite, Illegal, Retire SHALL be 0 regardless of MemReady.
REQ-029 Reset mid-instruction (any state incl. TRAP, MEMWRITE wait) SHALL abandon it with no write strobe after the reset edge; first cycle after release is FETCH.

Verification
REQ-030 lw, MemReady=1 always: FETCH,DECODE,MEMADR,MEMREAD,MEMWB (5 cycles); RegWrite=1 with ResultSrc=01 only in cycle 5; Retire in cycle 5.
REQ-031 sw, MemReady low 3 cycles in MEMWRITE: MemWrite=1 for 4 consecutive cycles, Retire on the 4th, then FETCH.
REQ-032 R-type funct3=000, funct7b5=1: ALUControl=1000 in EXECUTER; same with op=0010011 (addi, funct7b5=1): ALUControl=0000.
REQ-033 beq Zero=1 -> PCWrite=1 in BEQ; Zero=0 -> PCWrite=0; both 3 cycles, back to FETCH.
REQ-034 op=0000000 -> TRAP after DECODE, Illegal=1 held; reset pulse -> FETCH, Illegal=0.
REQ-035 FETCH with MemReady=0 for 5 cycles: IRWrite=PCWrite=0 throughout, state stays FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RV32 subset control unit: registered state, combinational decode of
// datapath selects and write strobes, with a sticky TRAP state for unknown opcodes.
module multicycle_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       Illegal,
   output logic       Retire,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [3:0] ALUControl
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b1000;
   localparam logic [3:0] ALU_SLT = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0110;
   localparam logic [3:0] ALU_AND = 4'b0111;

   state_t state_q, state_d;

   // funct7b5 only selects subtract for register-register ops (op[5]=1); addi ignores it
   function automatic logic [3:0] funct_decode(input logic [2:0] f3, input logic f7b5,
                                               input logic op5);
      case (f3)
         3'b000:  funct_decode = (f7b5 && op5) ? ALU_SUB : ALU_ADD;
         3'b010:  funct_decode = ALU_SLT;
         3'b110:  funct_decode = ALU_OR;
         3'b111:  funct_decode = ALU_AND;
         default: funct_decode = ALU_ADD;
      endcase
   endfunction

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    state_d = MemReady ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECUTER;
               OP_ITYPE:          state_d = S_EXECUTEI;
               OP_BRANCH:         state_d = S_BEQ;
               OP_JAL:            state_d = S_JAL;
               default:           state_d = S_TRAP;
            endcase
         end
         S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = MemReady ? S_MEMWB : S_MEMREAD;
         S_MEMWRITE: state_d = MemReady ? S_FETCH : S_MEMWRITE;
         S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
         S_MEMWB, S_ALUWB, S_BEQ:       state_d = S_FETCH;
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_TRAP;
      endcase
   end

   // Per-state datapath selects and strobes; strobes are suppressed while reset is held
   always_comb begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      Illegal    = 1'b0;
      Retire     = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = MemReady;
            PCWrite   = MemReady;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD:  AdrSrc = 1'b1;
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            Retire   = MemReady;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
            Retire    = 1'b1;
         end
         S_EXECUTER: begin
            ALUSrcA    = 2'b10;
            ALUControl = funct_decode(funct3, funct7b5, op[5]);
         end
         S_EXECUTEI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ALUControl = funct_decode(funct3, funct7b5, op[5]);
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
            Retire   = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA    = 2'b10;
            ALUControl = ALU_SUB;
            PCWrite    = Zero;
            Retire     = 1'b1;
         end
         S_JAL: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            PCWrite = 1'b1;
         end
         S_TRAP:     Illegal = 1'b1;
         default:    Illegal = 1'b1;
      endcase
      if (reset) begin
         PCWrite  = 1'b0;
         MemWrite = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
         Illegal  = 1'b0;
         Retire   = 1'b0;
      end else begin
         AdrSrc = AdrSrc;
      end
   end

   // Immediate format follows the opcode directly, forced to zero in TRAP
   always_comb begin
      ImmSrc = 2'b00;
      if (state_q == S_TRAP) begin
         ImmSrc = 2'b00;
      end else begin
         case (op)
            OP_LOAD, OP_ITYPE: ImmSrc = 2'b00;
            OP_STORE:          ImmSrc = 2'b01;
            OP_BRANCH:         ImmSrc = 2'b10;
            OP_JAL:            ImmSrc = 2'b11;
            default:           ImmSrc = 2'b00;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller: every cycle's full output word is
// compared against a hand-written expectation.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       MemReady;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal, Retire;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [3:0] ALUControl;

   int tests_run = 0;
   int tests_failed = 0;

   multicycle_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .MemReady(MemReady),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .Illegal(Illegal), .Retire(Retire),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
      .ALUControl(ALUControl)
   );

   always #5 clk = ~clk;

   logic [18:0] obs;
   assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal, Retire,
                 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};

   // Output word layout: pc adr mw ir rw ill ret | rs sa sb imm | alu
   function automatic logic [18:0] pk(input logic pc, input logic adr, input logic mw,
                                      input logic ir, input logic rw, input logic ill,
                                      input logic ret, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [1:0] imm, input logic [3:0] alu);
      return {pc, adr, mw, ir, rw, ill, ret, rs, sa, sb, imm, alu};
   endfunction

   function automatic logic [18:0] e_fetch(input logic rdy, input logic [1:0] imm);
      return pk(rdy, 1'b0, 1'b0, rdy, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, imm, 4'b0000);
   endfunction

   function automatic logic [18:0] e_decode(input logic [1:0] imm);
      return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 4'b0000);
   endfunction

   function automatic logic [18:0] e_aluwb(input logic [1:0] imm);
      return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, imm, 4'b0000);
   endfunction

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Apply inputs for one cycle, check mid-cycle, then advance past the next rising edge
   task automatic cyc(input string tag, input logic mr, input logic z, input logic [18:0] exp);
      MemReady = mr;
      Zero     = z;
      #3;
      chk_eq(tag, {13'd0, obs}, {13'd0, exp});
      @(posedge clk);
      #1;
   endtask

   // Assert reset asynchronously, check outputs while held, release after the next edge
   task automatic pulse_reset(input string tag, input logic mr, input logic [18:0] exp);
      MemReady = mr;
      reset    = 1'b1;
      #2;
      chk_eq(tag, {13'd0, obs}, {13'd0, exp});
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      op       = o;
      funct3   = f3;
      funct7b5 = f7;
   endtask

   logic [2:0]  r_f3  [4];
   logic [3:0]  r_alu [4];
   logic [18:0] quiet_fetch;

   initial begin
      reset    = 1'b1;
      MemReady = 1'b1;
      Zero     = 1'b0;
      set_instr(7'b0000011, 3'b010, 1'b0);
      #2;
      chk_eq("reset_hold", {13'd0, obs}, {13'd0, e_fetch(1'b0, 2'b00)});
      @(posedge clk);
      #1;
      reset = 1'b0;

      // lw with memory always ready: 5 cycles
      cyc("lw_fetch",   1'b1, 1'b0, e_fetch(1'b1, 2'b00));
      cyc("lw_decode",  1'b0, 1'b0, e_decode(2'b00));
      cyc("lw_memadr",  1'b1, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 4'b0000));
      cyc("lw_memread", 1'b1, 1'b0, pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000));
      cyc("lw_memwb",   1'b1, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0000));

      // sw with memory stalling 3 cycles in MEMWRITE
      set_instr(7'b0100011, 3'b010, 1'b0);
      cyc("sw_fetch",  1'b1, 1'b0, e_fetch(1'b1, 2'b01));
      cyc("sw_decode", 1'b1, 1'b0, e_decode(2'b01));
      cyc("sw_memadr", 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b01, 4'b0000));
      for (int i = 0; i < 3; i++)
         cyc("sw_memwrite_wait", 1'b0, 1'b0, pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0000));
      cyc("sw_memwrite_done", 1'b1, 1'b0, pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0000));

      // R-type sub, then addi with funct7b5 set
      set_instr(7'b0110011, 3'b000, 1'b1);
      cyc("sub_fetch",  1'b1, 1'b0, e_fetch(1'b1, 2'b00));
      cyc("sub_decode", 1'b1, 1'b0, e_decode(2'b00));
      cyc("sub_exec",   1'b1, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 4'b1000));
      cyc("sub_aluwb",  1'b1, 1'b0, e_aluwb(2'b00));
      set_instr(7'b0010011, 3'b000, 1'b1);
      cyc("addi_fetch",  1'b1, 1'b0, e_fetch(1'b1, 2'b00));
      cyc("addi_decode", 1'b1, 1'b0, e_decode(2'b00));
      cyc("addi_exec",   1'b1, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 4'b0000));
      cyc("addi_aluwb",  1'b1, 1'b0, e_aluwb(2'b00));

      // Remaining funct3 decodes on R-type
      r_f3[0] = 3'b010; r_alu[0] = 4'b0010;
      r_f3[1] = 3'b110; r_alu[1] = 4'b0110;
      r_f3[2] = 3'b111; r_alu[2] = 4'b0111;
      r_f3[3] = 3'b001; r_alu[3] = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         set_instr(7'b0110011, r_f3[k], 1'b1);
         cyc("r_fetch",  1'b1, 1'b0, e_fetch(1'b1, 2'b00));
         cyc("r_decode", 1'b1, 1'b0, e_decode(2'b00));
         cyc("r_exec",   1'b1, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, r_alu[k]));
         cyc("r_aluwb",  1'b1, 1'b0, e_aluwb(2'b00));
      end

      // beq taken then not taken
      set_instr(7'b1100011, 3'b000, 1'b0);
      cyc("beq1_fetch",  1'b1, 1'b1, e_fetch(1'b1, 2'b10));
      cyc("beq1_decode", 1'b1, 1'b1, e_decode(2'b10));
      cyc("beq1_taken",  1'b1, 1'b1, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00, 2'b10, 4'b1000));
      cyc("beq0_fetch",  1'b1, 1'b0, e_fetch(1'b1, 2'b10));
      cyc("beq0_decode", 1'b1, 1'b0, e_decode(2'b10));
      cyc("beq0_not",    1'b1, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00, 2'b10, 4'b1000));

      // jal
      set_instr(7'b1101111, 3'b000, 1'b0);
      cyc("jal_fetch",  1'b1, 1'b0, e_fetch(1'b1, 2'b11));
      cyc("jal_decode", 1'b1, 1'b0, e_decode(2'b11));
      cyc("jal_exec",   1'b1, 1'b0, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b11, 4'b0000));
      cyc("jal_aluwb",  1'b1, 1'b0, e_aluwb(2'b11));

      // Fetch stall for 5 cycles, then complete an addi to prove the state held
      set_instr(7'b0010011, 3'b111, 1'b0);
      for (int i = 0; i < 5; i++)
         cyc("fetch_stall", 1'b0, 1'b0, e_fetch(1'b0, 2'b00));
      cyc("stall_release", 1'b1, 1'b0, e_fetch(1'b1, 2'b00));
      cyc("stall_decode",  1'b1, 1'b0, e_decode(2'b00));
      cyc("andi_exec",     1'b1, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 4'b0111));
      cyc("andi_aluwb",    1'b1, 1'b0, e_aluwb(2'b00));

      // Illegal opcode: TRAP is sticky until reset
      set_instr(7'b0000000, 3'b000, 1'b0);
      cyc("ill_fetch",  1'b1, 1'b0, e_fetch(1'b1, 2'b00));
      cyc("ill_decode", 1'b1, 1'b0, e_decode(2'b00));
      for (int i = 0; i < 4; i++)
         cyc("trap_hold", 1'b1, 1'b1, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000));
      quiet_fetch = e_fetch(1'b0, 2'b00);
      pulse_reset("trap_reset", 1'b1, quiet_fetch);
      cyc("trap_exit_fetch", 1'b0, 1'b0, quiet_fetch);

      // Reset during a MEMWRITE wait abandons the store
      set_instr(7'b0100011, 3'b010, 1'b0);
      cyc("swr_fetch",  1'b1, 1'b0, e_fetch(1'b1, 2'b01));
      cyc("swr_decode", 1'b1, 1'b0, e_decode(2'b01));
      cyc("swr_memadr", 1'b1, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b01, 4'b0000));
      cyc("swr_wait",   1'b0, 1'b0, pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0000));
      pulse_reset("swr_reset", 1'b1, e_fetch(1'b0, 2'b01));
      cyc("swr_after",  1'b0, 1'b0, e_fetch(1'b0, 2'b01));
      cyc("swr_refetch", 1'b1, 1'b0, e_fetch(1'b1, 2'b01));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
